// File: rtl/pim_pkg.sv
// Shared PIM constants, FSM state encoding and slice addressing used by the
// readback serializer and its nibble interleaver.
package pim_pkg;

    localparam int PIM_VEC_W   = 256;
    localparam int PIM_WORD_W  = 32;
    localparam int PIM_NIB_W   = 4;
    localparam int PIM_WORDS   = 16;
    localparam int PIM_SLICE_W = PIM_VEC_W / PIM_WORDS;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_DONE = 2'd2
    } pim_state_e;

    // Low bit of slice k; slice 0 sits at the top of the vector.
    function automatic int pim_slice_lo(input int k, input int num_words);
        return PIM_SLICE_W * (num_words - 1 - k);
    endfunction

endpackage

// File: rtl/weight_readback_serializer_if.sv
// Load/abort inputs and valid/ready word stream of the weight readback
// serializer; slave is the serializer side.
interface weight_readback_serializer_if import pim_pkg::*; #(
    parameter int NUM_WORDS = PIM_WORDS,
    parameter int WORD_W    = PIM_WORD_W
);

    localparam int VEC_W = PIM_SLICE_W * NUM_WORDS;
    localparam int CNT_W = $clog2(NUM_WORDS);

    logic             i_load;
    logic [VEC_W-1:0] i_cam_data;
    logic [VEC_W-1:0] i_cim_data;
    logic             i_abort;
    logic             o_valid;
    logic             i_ready;
    logic [WORD_W-1:0] o_data;
    logic [CNT_W-1:0] o_counter;
    logic             o_busy;
    logic             o_done;

    modport master (
        output i_load, i_cam_data, i_cim_data, i_abort, i_ready,
        input  o_valid, o_data, o_counter, o_busy, o_done
    );

    modport slave (
        input  i_load, i_cam_data, i_cim_data, i_abort, i_ready,
        output o_valid, o_data, o_counter, o_busy, o_done
    );

endinterface

// File: rtl/pim_nibble_interleave.sv
// Packs one 16-bit CAM slice and one 16-bit CIM slice into a bus word,
// alternating nibbles with the CAM nibble in the upper position.
module pim_nibble_interleave import pim_pkg::*; (
    input  logic [PIM_SLICE_W-1:0]   cam,
    input  logic [PIM_SLICE_W-1:0]   cim,
    output logic [2*PIM_SLICE_W-1:0] word
);

    localparam int NIBS = PIM_SLICE_W / PIM_NIB_W;

    always_comb begin
        word = '0;
        for (int i = 0; i < NIBS; i++) begin
            word[2*PIM_NIB_W*i + PIM_NIB_W +: PIM_NIB_W] = cam[PIM_NIB_W*i +: PIM_NIB_W];
            word[2*PIM_NIB_W*i             +: PIM_NIB_W] = cim[PIM_NIB_W*i +: PIM_NIB_W];
        end
    end

endmodule

// File: rtl/weight_readback_serializer.sv
// Captures CAM/CIM vectors from the PIM macro and streams them as interleaved
// 32-bit words, one slice per handshake, with a done pulse after the last word.
module weight_readback_serializer import pim_pkg::*; #(
    parameter int NUM_WORDS = PIM_WORDS,
    parameter int WORD_W    = PIM_WORD_W
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    weight_readback_serializer_if.slave  bus
);

    localparam int VEC_W = PIM_SLICE_W * NUM_WORDS;
    localparam int CNT_W = $clog2(NUM_WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(NUM_WORDS - 1);

    pim_state_e        state;
    logic [VEC_W-1:0]  cam_sh;
    logic [VEC_W-1:0]  cim_sh;
    logic              valid;
    logic              busy;
    logic              done;
    logic [CNT_W-1:0]  counter;
    logic [WORD_W-1:0] data;

    logic [VEC_W-1:0]         src_cam;
    logic [VEC_W-1:0]         src_cim;
    logic [CNT_W-1:0]         sel;
    logic [PIM_SLICE_W-1:0]   cam_slice;
    logic [PIM_SLICE_W-1:0]   cim_slice;
    logic [2*PIM_SLICE_W-1:0] next_word;

    // In IDLE the first word comes straight from the inputs so it can be
    // registered in the same cycle the vectors are captured.
    always_comb begin
        src_cam = cam_sh;
        src_cim = cim_sh;
        sel     = counter + CNT_W'(1);
        if (state == ST_IDLE) begin
            src_cam = bus.i_cam_data;
            src_cim = bus.i_cim_data;
            sel     = '0;
        end
        cam_slice = src_cam[pim_slice_lo(int'(sel), NUM_WORDS) +: PIM_SLICE_W];
        cim_slice = src_cim[pim_slice_lo(int'(sel), NUM_WORDS) +: PIM_SLICE_W];
    end

    pim_nibble_interleave u_interleave (
        .cam  (cam_slice),
        .cim  (cim_slice),
        .word (next_word)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= ST_IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            counter <= '0;
            data    <= '0;
            // NOTE: the shadow vectors are ordinary flops, not a RAM, so they
            // are cleared with everything else; no stale weights survive reset.
            cam_sh  <= '0;
            cim_sh  <= '0;
        end else if (bus.i_abort) begin
            state   <= ST_IDLE;
            valid   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            counter <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    if (bus.i_load) begin
                        cam_sh  <= bus.i_cam_data;
                        cim_sh  <= bus.i_cim_data;
                        counter <= '0;
                        data    <= next_word;
                        valid   <= 1'b1;
                        busy    <= 1'b1;
                        state   <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (valid && bus.i_ready) begin
                        if (counter == LAST) begin
                            valid   <= 1'b0;
                            counter <= '0;
                            done    <= 1'b1;
                            state   <= ST_DONE;
                        end else begin
                            counter <= counter + CNT_W'(1);
                            data    <= next_word;
                        end
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    valid <= 1'b0;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.o_valid   = valid;
    assign bus.o_data    = data;
    assign bus.o_counter = counter;
    assign bus.o_busy    = busy;
    assign bus.o_done    = done;

endmodule

// File: tb/tb_weight_readback_serializer.sv
// Self-checking bench: table of transfers drained through a scoreboard, plus
// hand-written load-ignore, abort and reset corner sequences.
module tb_weight_readback_serializer;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  cnt;
    } exp_t;

    typedef struct {
        logic [255:0] cam;
        logic [255:0] cim;
        bit           rand_ready;
        logic [31:0]  exp_w0;
        logic [31:0]  exp_w3;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    weight_readback_serializer_if bus ();

    weight_readback_serializer dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int           n_checks = 0;
    int           n_err    = 0;
    int           hs_cnt;
    int           done_cnt;
    exp_t         sb_q[$];
    logic [31:0]  got_w[16];
    logic [255:0] rt_cam;
    logic [255:0] rt_cim;
    bit           prev_stall;
    logic [31:0]  prev_d;
    logic [3:0]   prev_c;
    vec_t         tbl[5];

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Independent reference: spec formula for word k of a vector pair.
    function automatic logic [31:0] model_word(input logic [255:0] cam, input logic [255:0] cim, input int k);
        logic [15:0] a;
        logic [15:0] b;
        a = cam[255-16*k -: 16];
        b = cim[255-16*k -: 16];
        return {a[15:12], b[15:12], a[11:8], b[11:8], a[7:4], b[7:4], a[3:0], b[3:0]};
    endfunction

    function automatic logic [255:0] pat_vec(input bit invert);
        logic [255:0] v;
        logic [3:0]   kk;
        v = '0;
        for (int k = 0; k < 16; k++) begin
            kk = invert ? ~4'(k) : 4'(k);
            v[255-16*k -: 16] = {4{kk}};
        end
        return v;
    endfunction

    function automatic logic [255:0] rand_vec();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[32*i +: 32] = $urandom;
        return v;
    endfunction

    function automatic vec_t mk(input logic [255:0] cam, input logic [255:0] cim, input bit rr,
                                input logic [31:0] w0, input logic [31:0] w3);
        vec_t t;
        t.cam = cam; t.cim = cim; t.rand_ready = rr; t.exp_w0 = w0; t.exp_w3 = w3;
        return t;
    endfunction

    // One cycle, entered and left at a negedge: sample outputs, score the
    // handshake that the driven inputs will cause at the coming posedge.
    task automatic step(input logic rdy, input logic ld, input logic abt);
        logic        v;
        logic [31:0] d;
        logic [3:0]  c;
        exp_t        e;
        v = bus.o_valid;
        d = bus.o_data;
        c = bus.o_counter;
        if (bus.o_done) done_cnt++;
        if (prev_stall && v) begin
            check("hold_data", d, prev_d);
            check("hold_counter", c, prev_c);
        end
        bus.i_ready = rdy;
        bus.i_load  = ld;
        bus.i_abort = abt;
        if (v && rdy && !abt) begin
            hs_cnt++;
            check("sb_nonempty", sb_q.size() != 0, 1'b1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("word_data", d, e.data);
                check("word_counter", c, e.cnt);
            end
            got_w[c] = d;
            rt_cam[255-16*int'(c) -: 16] = {d[31:28], d[23:20], d[15:12], d[7:4]};
            rt_cim[255-16*int'(c) -: 16] = {d[27:24], d[19:16], d[11:8], d[3:0]};
        end
        prev_stall = v && !rdy;
        prev_d     = d;
        prev_c     = c;
        @(negedge clk);
        bus.i_ready = 1'b0;
        bus.i_load  = 1'b0;
        bus.i_abort = 1'b0;
    endtask

    task automatic load_vec(input logic [255:0] cam, input logic [255:0] cim);
        exp_t e;
        sb_q.delete();
        for (int k = 0; k < 16; k++) begin
            e.data = model_word(cam, cim, k);
            e.cnt  = 4'(k);
            sb_q.push_back(e);
        end
        hs_cnt   = 0;
        done_cnt = 0;
        rt_cam   = '0;
        rt_cim   = '0;
        for (int k = 0; k < 16; k++) got_w[k] = 'x;
        bus.i_cam_data = cam;
        bus.i_cim_data = cim;
        step(1'b0, 1'b1, 1'b0);
        check("first_valid_latency", bus.o_valid, 1'b1);
        check("first_counter", bus.o_counter, 4'd0);
        check("busy_in_send", bus.o_busy, 1'b1);
    endtask

    task automatic drain(input bit rand_ready, output int done_cyc);
        done_cyc = -1;
        for (int n = 0; n < 400 && done_cnt == 0; n++) begin
            step(rand_ready ? 1'($urandom_range(0, 1)) : 1'b1, 1'b0, 1'b0);
            if (done_cnt != 0 && done_cyc < 0) done_cyc = n;
        end
    endtask

    task automatic run_to_counter(input logic [3:0] target);
        for (int n = 0; n < 100 && !(bus.o_valid && bus.o_counter == target); n++)
            step(1'b1, 1'b0, 1'b0);
        check("reached_counter", bus.o_counter, target);
    endtask

    task automatic check_complete(input logic [255:0] cam, input logic [255:0] cim);
        check("handshake_count", hs_cnt, 16);
        check("done_count", done_cnt, 1);
        check("sb_drained", sb_q.size(), 0);
        check("roundtrip_cam", rt_cam, cam);
        check("roundtrip_cim", rt_cim, cim);
        check("idle_done_low", bus.o_done, 1'b0);
        check("idle_busy_low", bus.o_busy, 1'b0);
        check("idle_valid_low", bus.o_valid, 1'b0);
    endtask

    initial begin
        int           done_cyc;
        logic [255:0] cam_a;
        logic [255:0] cim_a;

        bus.i_load = 1'b0; bus.i_abort = 1'b0; bus.i_ready = 1'b0;
        bus.i_cam_data = '0; bus.i_cim_data = '0;
        prev_stall = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_busy", bus.o_busy, 1'b0);
        check("rst_done", bus.o_done, 1'b0);
        check("rst_counter", bus.o_counter, 4'd0);
        check("rst_data", bus.o_data, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        tbl[0] = mk({64{4'hA}}, {64{4'h5}}, 1'b0, 32'hA5A5A5A5, 32'hA5A5A5A5);
        tbl[1] = mk(pat_vec(1'b0), pat_vec(1'b1), 1'b0, 32'h0F0F0F0F, 32'h3C3C3C3C);
        tbl[2] = mk(pat_vec(1'b0), pat_vec(1'b1), 1'b1, 32'h0F0F0F0F, 32'h3C3C3C3C);
        cam_a = rand_vec();
        cim_a = rand_vec();
        tbl[3] = mk(cam_a, cim_a, 1'b1, model_word(cam_a, cim_a, 0), model_word(cam_a, cim_a, 3));
        cam_a = rand_vec();
        cim_a = rand_vec();
        tbl[4] = mk(cam_a, cim_a, 1'b0, model_word(cam_a, cim_a, 0), model_word(cam_a, cim_a, 3));

        for (int t = 0; t < 5; t++) begin
            load_vec(tbl[t].cam, tbl[t].cim);
            drain(tbl[t].rand_ready, done_cyc);
            if (!tbl[t].rand_ready) check("done_one_cycle_after_last", done_cyc, 16);
            check("word0", got_w[0], tbl[t].exp_w0);
            check("word3", got_w[3], tbl[t].exp_w3);
            check_complete(tbl[t].cam, tbl[t].cim);
        end

        // Load strobe mid-transfer must not disturb the shadow vectors.
        load_vec({64{4'hA}}, {64{4'h5}});
        run_to_counter(4'd7);
        bus.i_cam_data = {64{4'h3}};
        bus.i_cim_data = {64{4'hC}};
        step(1'b1, 1'b1, 1'b0);
        drain(1'b0, done_cyc);
        check_complete({64{4'hA}}, {64{4'h5}});

        // Abort at counter 5, then a fresh transfer restarts at word 0.
        load_vec(tbl[3].cam, tbl[3].cim);
        run_to_counter(4'd5);
        step(1'b1, 1'b0, 1'b1);
        check("abort_valid", bus.o_valid, 1'b0);
        check("abort_counter", bus.o_counter, 4'd0);
        check("abort_busy", bus.o_busy, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b0);
        check("abort_no_done", done_cnt, 0);
        load_vec(tbl[1].cam, tbl[1].cim);
        drain(1'b0, done_cyc);
        check_complete(tbl[1].cam, tbl[1].cim);

        // Abort coinciding with the final handshake suppresses o_done.
        load_vec(tbl[4].cam, tbl[4].cim);
        run_to_counter(4'd15);
        step(1'b1, 1'b0, 1'b1);
        check("abort_last_valid", bus.o_valid, 1'b0);
        repeat (2) step(1'b1, 1'b0, 1'b0);
        check("abort_last_no_done", done_cnt, 0);

        // Synchronous reset at counter 9 clears everything, no done pulse.
        load_vec(tbl[0].cam, tbl[0].cim);
        run_to_counter(4'd9);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", bus.o_valid, 1'b0);
        check("midrst_busy", bus.o_busy, 1'b0);
        check("midrst_done", bus.o_done, 1'b0);
        check("midrst_counter", bus.o_counter, 4'd0);
        check("midrst_data", bus.o_data, 32'd0);
        rst = 1'b0;
        prev_stall = 1'b0;
        sb_q.delete();
        repeat (3) step(1'b1, 1'b0, 1'b0);
        check("midrst_no_done", done_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
